// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory for the MEM stage: B/H/W loads and stores with
// byte lanes, sign/zero extension, configurable latency and fault detection.
module data_memory_bytelane #(
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic        lat_write;
  logic [2:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          finish;
  logic          fault;
  logic          range_fault;
  logic          size_fault;
  logic [3:0]    be;
  logic [31:0]   lanes;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  assign idx       = lat_addr[AW+1:2];
  assign off       = lat_addr[1:0];
  assign finish    = (state == BUSY) && (cnt == '0);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign stall     = req_valid && !rsp_valid;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    range_fault = ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
    size_fault  = 1'b0;
    case (lat_size)
      3'b000:  size_fault = 1'b0;
      3'b001:  size_fault = off[0];
      3'b010:  size_fault = (off != 2'b00);
      3'b100:  size_fault = lat_write;
      3'b101:  size_fault = lat_write || off[0];
      default: size_fault = 1'b1;
    endcase
    fault = range_fault || size_fault;
  end

  always_comb begin
    be    = 4'b1111;
    lanes = lat_wdata;
    case (lat_size[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        lanes = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        lanes = {2{lat_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        lanes = lat_wdata;
      end
    endcase
  end

  // The addressed byte/half is shifted down to bit 0 before extension.
  always_comb begin
    word      = mem[idx];
    shifted   = word >> {off, 3'b000};
    load_data = word;
    case (lat_size)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      lat_write <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= WAIT_INIT;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 3'd1;
      end
      if (finish) begin
        rsp_fault <= fault;
        rsp_rdata <= (fault || lat_write) ? '0 : load_data;
      end
    end
  end

  // Storage has no reset; the rst guard lets reset win on the commit edge.
  always_ff @(posedge clk) begin
    if (!rst && finish && lat_write && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench for data_memory_bytelane: three builds (1, 0 and 7 wait states).
module tb_data_memory_bytelane;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [2:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_fault [3];
  logic        stall     [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc [3];
  logic done = 1'b0;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_bytelane #(
      .DEPTH_WORDS(512),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 7))
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_size (req_size[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_fault(rsp_fault[g]),
      .stall    (stall[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (rsp_valid[k]) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", {31'b0, rsp_valid[k]}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_dut", 32'(k), 32'(e.k));
            check("rsp_rdata", rsp_rdata[k], e.rdata);
            check("rsp_fault", {31'b0, rsp_fault[k]}, {31'b0, e.fault});
            check("rsp_latency", 32'(cyc), 32'(e.due));
            check("ready_in_done", {31'b0, req_ready[k]}, 32'd0);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic access(input int k, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_f,
                        input logic gap_chk);
    bit acc;
    acc = 1'b0;
    req_write[k] = wr;
    req_size[k]  = sz;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!acc && req_ready[k]) begin
        acc = 1'b1;
        sb.push_back('{k: k, rdata: exp_rd, fault: exp_f, due: cyc + wc(k) + 2});
        if (gap_chk) check("accept_gap", 32'(cyc - last_acc[k]), 32'(wc(k) + 3));
        last_acc[k] = cyc;
      end
      if (rsp_valid[k]) break;
      check("stall_high", {31'b0, stall[k]}, 32'd1);
    end
    if (!rsp_valid[k]) check("rsp_timeout", {31'b0, rsp_valid[k]}, 32'd1);
    else check("stall_low", {31'b0, stall[k]}, 32'd0);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic run_b2b(input int k);
    access(k, 1'b1, SZ_W,  32'h100, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0);
    access(k, 1'b1, SZ_B,  32'h103, 32'h0000007F, 32'h0,        1'b0, 1'b1);
    access(k, 1'b0, SZ_W,  32'h100, 32'h0,        32'h7FFEF00D, 1'b0, 1'b1);
    access(k, 1'b0, SZ_H,  32'h102, 32'h0,        32'h00007FFE, 1'b0, 1'b1);
    access(k, 1'b0, SZ_BU, 32'h101, 32'h0,        32'h000000F0, 1'b0, 1'b1);
    access(k, 1'b0, SZ_B,  32'h101, 32'h0,        32'hFFFFFFF0, 1'b0, 1'b1);
  endtask

  initial begin
    int pulses;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_size[k]  = '0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      last_acc[k]  = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", {31'b0, req_ready[k]}, 32'd1);
      check("reset_valid", {31'b0, rsp_valid[k]}, 32'd0);
      check("reset_rdata", rsp_rdata[k], 32'd0);
      check("reset_fault", {31'b0, rsp_fault[k]}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Latency and basic word access.
    access(0, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Byte lanes.
    access(0, 1'b1, SZ_W, 32'h20, 32'h00000000, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_B, 32'h21, 32'h000000A5, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_H, 32'h22, 32'h00001234, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_W, 32'h20, 32'h0, 32'h1234A500, 1'b0, 1'b0);
    @(negedge clk);
    check("rdata_hold", rsp_rdata[0], 32'h1234A500);
    check("valid_single_pulse", {31'b0, rsp_valid[0]}, 32'd0);
    @(posedge clk);
    #1;

    // Extension.
    access(0, 1'b0, SZ_B,  32'h21, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0);
    access(0, 1'b0, SZ_BU, 32'h21, 32'h0, 32'h000000A5, 1'b0, 1'b0);
    access(0, 1'b0, SZ_H,  32'h22, 32'h0, 32'h00001234, 1'b0, 1'b0);
    access(0, 1'b0, SZ_HU, 32'h20, 32'h0, 32'h0000A500, 1'b0, 1'b0);
    access(0, 1'b0, SZ_H,  32'h20, 32'h0, 32'hFFFFA500, 1'b0, 1'b0);

    // Faults: misaligned, out of range, illegal sizes; memory untouched.
    access(0, 1'b0, SZ_W,   32'h22,  32'h0,        32'h0, 1'b1, 1'b0);
    access(0, 1'b0, SZ_H,   32'h21,  32'h0,        32'h0, 1'b1, 1'b0);
    access(0, 1'b1, SZ_B,   32'h800, 32'h000000FF, 32'h0, 1'b1, 1'b0);
    access(0, 1'b1, SZ_BU,  32'h20,  32'h00000077, 32'h0, 1'b1, 1'b0);
    access(0, 1'b0, 3'b011, 32'h20,  32'h0,        32'h0, 1'b1, 1'b0);
    access(0, 1'b0, SZ_W,   32'h20,  32'h0, 32'h1234A500, 1'b0, 1'b0);

    // Reset in the BUSY cycle abandons the store.
    access(0, 1'b1, SZ_W, 32'h40, 32'h11111111, 32'h0, 1'b0, 1'b0);
    req_write[0] = 1'b1;
    req_size[0]  = SZ_W;
    req_addr[0]  = 32'h40;
    req_wdata[0] = 32'h22222222;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("rst_test_accept", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) check("ready_after_rst", {31'b0, req_ready[0]}, 32'd1);
      if (rsp_valid[0]) pulses++;
    end
    check("rst_no_rsp", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    access(0, 1'b0, SZ_W, 32'h40, 32'h0, 32'h11111111, 1'b0, 1'b0);

    // Back-to-back throughput for the 0 and 7 wait-state builds.
    run_b2b(1);
    run_b2b(2);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog_done", {31'b0, done}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised, byte-addressed data memory for the pipelined datapath, replacing the word-only, always-ready data memory. It supports RISC-V load/store sizes (byte, halfword, word) with per-byte write lanes and sign/zero extension. It has a configurable access latency behind a request/response handshake. It also flags misaligned, out-of-range and illegal-size accesses. It sits in the MEM stage; its `stall` output freezes the upstream pipeline registers while an access is in flight.

## Interface
- `DEPTH_WORDS`, 512: memory depth in 32-bit words.
- `WAIT_CYCLES`, 1: extra wait states per access, legal range 0..7.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: access request from the MEM stage.
- `req_ready` out 1: block is idle and can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle pulse when the access completes.
- `rsp_rdata` out 32: load result after extension; 0 for stores and faults.
- `rsp_fault` out 1: qualified by `rsp_valid`; access rejected.
- `stall` out 1: `req_valid && !rsp_valid`.

## Operation
- FSM states:
  - IDLE: `req_ready=1`; `req_valid` moves to BUSY and latches write, size, addr and wdata.
  - BUSY: wait-state counter loads `WAIT_CYCLES` on entry and decrements each cycle; at 0, move to DONE.
  - DONE: `rsp_valid=1`, `req_ready=0`; always return to IDLE next cycle.
- Word index = `addr[31:2]`; byte offset = `addr[1:0]`.
- Fault conditions, evaluated on the latched request:
  - word index >= `DEPTH_WORDS`;
  - H/HU with `addr[0]=1`;
  - W with `addr[1:0]!=0`;
  - size 011, 110 or 111;
  - store with size BU or HU.
- A faulting access still takes the full latency. It never modifies memory and returns `rsp_rdata=0`, `rsp_fault=1`.
- Stores:
  - byte-enable mask: B gives `4'b0001<<off`, H gives `4'b0011<<off`, W gives `4'b1111`.
  - lane data: B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2.
  - Only enabled bytes change.
  - Commit happens on the BUSY→DONE edge.
- Loads:
  - memory is read at the BUSY→DONE edge into the `rsp_rdata` register.
  - selected byte or half is sign-extended (B, H) or zero-extended (BU, HU).
- `rsp_rdata` and `rsp_fault` hold their values until the next DONE. `rsp_valid` is the only strobe.
- Memory contents are not initialised or reset. Reading a never-written location returns X in simulation.

## Timing
- Request accepted on edge N (IDLE, `req_valid=1`). `rsp_valid` is high during cycle N+1+`WAIT_CYCLES`+1, i.e. `WAIT_CYCLES`+2 cycles after the accept cycle.
- Maximum throughput: one access per `WAIT_CYCLES`+3 cycles.
- `stall` is combinational. The pipeline advances on the edge that ends the DONE cycle. `req_ready=0` in DONE, so the held request is not re-accepted.
- Reset values: state IDLE, counter 0, `rsp_valid=0`, `rsp_rdata=0`, `rsp_fault=0`, `req_ready=1` in the first post-reset cycle.
- Reset during BUSY abandons the access: no store commit and no response.
- Reset on the commit edge: reset wins, memory is unchanged.
- `req_*` inputs are ignored outside IDLE; changes mid-access have no effect.

## Test plan
- Latency, `WAIT_CYCLES=1`: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - `rsp_valid` appears 3 cycles after each accept.
  - read returns 0xDEADBEEF, `rsp_fault=0`.
  - `stall` is high for the 3 cycles before the response and low in the response cycle.
- Byte lanes: SW 0x00000000 to 0x20, then SB 0x000000A5 to 0x21, then SH 0x00001234 to 0x22. LW 0x20 → 0x1234A500.
- Extension: with word 0x20 = 0x1234A500:
  - LB 0x21 → 0xFFFFFFA5; LBU 0x21 → 0x000000A5;
  - LH 0x22 → 0x00001234; LHU 0x20 → 0x0000A500; LH 0x20 → 0xFFFFA500.
- Faults:
  - LW 0x22, LH 0x21, SB to byte address `4*DEPTH_WORDS`, store with size 100, load with size 011 → each gives `rsp_fault=1`, `rsp_rdata=0`.
  - Memory is unchanged afterwards (LW 0x20 still 0x1234A500).
- Reset mid-access: with word 0x40 = 0x11111111, issue SW 0x22222222 to 0x40 and assert `rst` in the BUSY cycle.
  - `rsp_valid` never pulses; `req_ready=1` after reset.
  - LW 0x40 → 0x11111111.
- `WAIT_CYCLES=0` and `WAIT_CYCLES=7` builds: back-to-back `req_valid` held high → accepts spaced exactly 3 and 10 cycles apart; all data correct.
